layer_mac_sequencer: RTL and testbench
======================================

# layer_mac_sequencer

Parametrised per-layer input/neuron sequencer for the neural-network datapath. It generalises the fixed two-ack layer counter to N_IN inputs per neuron and N_OUT neurons per layer. It drives the input and neuron indices to the weight and activation memories, and signals the MAC stage once per neuron and the next layer once per layer. Downstream back-pressure holds each neuron result until it is consumed.

## Interface
- N_IN, default 2: inputs (products) accumulated per neuron; must be ≥1.
- N_OUT, default 1: neurons per layer; must be ≥1.
- IW, default $clog2(N_IN+1): width of in_idx; wide enough to hold the bias slot index N_IN.
- NW, default max(1,$clog2(N_OUT)): width of neu_idx.
- clk, input, 1: clock; all state updates on the falling edge, matching the rest of the layer.
- rst, input, 1: reset, asynchronous, active-low.
- start, input, 1: begin a layer; sampled in IDLE only.
- ack, input, 1: one input product accepted this cycle; counted in ACC/BIAS only.
- mac_rdy, input, 1: MAC/activation stage accepts the current neuron result.
- in_idx, output, IW: current input index.
- neu_idx, output, NW: current neuron index.
- bias_sel, output, 1: high while in BIAS; tied 0 when the bias feature is compiled out.
- ack__mac, output, 1: neuron accumulation complete; held until accepted.
- ack__layer, output, 1: one-cycle pulse, layer complete.
- busy, output, 1: high in every state except IDLE.

## Operation
- States: IDLE, ACC, BIAS (present only with the bias feature), FIRE.
- Reset (rst=0): state IDLE; in_idx=0, neu_idx=0, bias_sel=0, ack__mac=0, ack__layer=0, busy=0. Reset is asynchronous and valid in any state, including mid-layer; no partial result is signalled afterwards.
- IDLE:
  - start=1 → ACC with in_idx=0, neu_idx=0.
  - ack and mac_rdy are ignored.
- ACC:
  - ack=1 with in_idx<N_IN-1 → in_idx+1.
  - ack=1 with in_idx=N_IN-1 → FIRE, or BIAS when the feature is compiled in. in_idx becomes N_IN when entering BIAS and is held at N_IN-1 when entering FIRE.
  - ack=0 → hold.
- BIAS:
  - bias_sel=1 and in_idx=N_IN.
  - ack=1 → FIRE with bias_sel=0.
- FIRE:
  - ack__mac=1; ack is ignored.
  - mac_rdy=1 with neu_idx<N_OUT-1 → ACC, with neu_idx+1, in_idx=0, ack__mac=0.
  - mac_rdy=1 with neu_idx=N_OUT-1 → IDLE, with ack__layer=1 for exactly one cycle, ack__mac=0, in_idx=0, neu_idx=0, busy=0.
- start while busy is ignored; it never restarts a layer.
- Counters never wrap past N_IN (or N_IN-1) / N_OUT-1. Unsigned arithmetic, IW/NW bits, no overflow for legal parameters.
- N_IN=1: each ack in ACC moves straight to FIRE (or BIAS).

## Timing
- All outputs are registered and change only on the falling edge of clk, or asynchronously on reset.
- Latency, last ack to ack__mac: ack sampled at edge k → ack__mac high after edge k. With the bias feature, one additional accepted ack in BIAS is required.
- ack__mac is high for at least one cycle even if mac_rdy is already high on entry. mac_rdy is sampled only at edges where ack__mac is already 1.
- Accept to next input: mac_rdy sampled at edge m → ACC, with in_idx=0 valid after edge m. The first ack is counted at edge m+1 at the earliest.
- ack__layer: high after the accepting edge m, low after edge m+1. start at edge m+1 is honoured because the state is already IDLE.
- Minimum layer time without bias, at ack and mac_rdy every cycle: 1 + N_OUT·(N_IN+1) cycles.

## Configuration
- LAYER_SEQ_BIAS_EN defined:
  - The BIAS state exists.
  - Each neuron needs N_IN+1 acks; the final ack is taken with in_idx=N_IN and bias_sel=1.
- LAYER_SEQ_BIAS_EN undefined:
  - There is no BIAS state and bias_sel is constant 0.
  - Each neuron needs N_IN acks; in_idx never exceeds N_IN-1.

## Test plan
- Defaults (N_IN=2, N_OUT=1), bias off, mac_rdy=1, start then ack on 2 consecutive cycles → in_idx 0,1. ack__mac high for 1 cycle after the 2nd ack. ack__layer pulses once, then busy=0.
- N_IN=3, N_OUT=4, bias off, acks with random gaps, mac_rdy held 0 for 5 cycles in each FIRE → ack__mac held 5+ cycles. Extra acks during FIRE are not counted. neu_idx steps 0→3. Exactly 4 ack__mac rises and 1 ack__layer.
- LAYER_SEQ_BIAS_EN defined, N_IN=2, N_OUT=2 → per neuron in_idx sequence 0,1,2. bias_sel=1 only while in_idx=2. ack__mac follows the 3rd ack.
- N_IN=1, N_OUT=1, start asserted again in the cycle after ack__layer → new layer begins. start pulses while busy have no effect.
- rst low mid-ACC (in_idx=1, neu_idx=2) → all outputs 0 immediately, without waiting for a clock edge. After release, no ack__mac until a fresh start plus N_IN acks.

Source files
------------

// File: rtl/layer_mac_sequencer.sv
// rtl/layer_mac_sequencer.sv - per-layer input/neuron index sequencer; optional bias slot via LAYER_SEQ_BIAS_EN
module layer_mac_sequencer #(
  parameter int N_IN  = 2,
  parameter int N_OUT = 1,
  parameter int IW    = $clog2(N_IN + 1),
  parameter int NW    = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          ack,
  input  logic          mac_rdy,
  output logic [IW-1:0] in_idx,
  output logic [NW-1:0] neu_idx,
  output logic          bias_sel,
  output logic          ack__mac,
  output logic          ack__layer,
  output logic          busy
);

`ifdef LAYER_SEQ_BIAS_EN
  typedef enum logic [1:0] {S_IDLE, S_ACC, S_BIAS, S_FIRE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_ACC, S_FIRE} state_t;
`endif

  localparam logic [IW-1:0] IN_LAST  = IW'(N_IN - 1);
  localparam logic [NW-1:0] NEU_LAST = NW'(N_OUT - 1);
`ifdef LAYER_SEQ_BIAS_EN
  localparam logic [IW-1:0] IN_BIAS  = IW'(N_IN);
`endif

  state_t          state_q;
  logic [IW-1:0]   in_idx_q;
  logic [NW-1:0]   neu_idx_q;
  logic            ack_mac_q;
  logic            ack_layer_q;
  logic            busy_q;
`ifdef LAYER_SEQ_BIAS_EN
  logic            bias_sel_q;
`endif

  // Sequencer FSM: walks inputs per neuron, then neurons per layer; all outputs registered on the falling edge
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      in_idx_q    <= '0;
      neu_idx_q   <= '0;
      ack_mac_q   <= 1'b0;
      ack_layer_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef LAYER_SEQ_BIAS_EN
      bias_sel_q  <= 1'b0;
`endif
    end else begin
      // layer-done is a single-cycle pulse
      ack_layer_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_ACC;
            in_idx_q  <= '0;
            neu_idx_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        S_ACC: begin
          if (ack) begin
            if (in_idx_q == IN_LAST) begin
`ifdef LAYER_SEQ_BIAS_EN
              state_q    <= S_BIAS;
              in_idx_q   <= IN_BIAS;
              bias_sel_q <= 1'b1;
`else
              state_q    <= S_FIRE;
              ack_mac_q  <= 1'b1;
`endif
            end else begin
              in_idx_q <= in_idx_q + 1'b1;
            end
          end
        end
`ifdef LAYER_SEQ_BIAS_EN
        S_BIAS: begin
          if (ack) begin
            state_q    <= S_FIRE;
            bias_sel_q <= 1'b0;
            ack_mac_q  <= 1'b1;
          end
        end
`endif
        S_FIRE: begin
          // mac_rdy only matters once ack__mac is already visible, so the result is shown for at least one cycle
          if (mac_rdy) begin
            ack_mac_q <= 1'b0;
            in_idx_q  <= '0;
            if (neu_idx_q == NEU_LAST) begin
              state_q     <= S_IDLE;
              neu_idx_q   <= '0;
              ack_layer_q <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              state_q   <= S_ACC;
              neu_idx_q <= neu_idx_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_idx     = in_idx_q;
  assign neu_idx    = neu_idx_q;
  assign ack__mac   = ack_mac_q;
  assign ack__layer = ack_layer_q;
  assign busy       = busy_q;
`ifdef LAYER_SEQ_BIAS_EN
  assign bias_sel   = bias_sel_q;
`else
  assign bias_sel   = 1'b0;
`endif

endmodule

// File: tb/tb_layer_mac_sequencer.sv
// tb/tb_layer_mac_sequencer.sv - scoreboard bench for layer_mac_sequencer
module tb_layer_mac_sequencer;

  localparam int A_IN  = 3;
  localparam int A_OUT = 4;
  localparam int A_IW  = $clog2(A_IN + 1);
  localparam int A_NW  = $clog2(A_OUT);
`ifdef LAYER_SEQ_BIAS_EN
  localparam int BIAS  = 1;
`else
  localparam int BIAS  = 0;
`endif
  localparam int NACK   = A_IN + BIAS;
  localparam int NACK_B = 1 + BIAS;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic            start = 1'b0, ack = 1'b0, mac_rdy = 1'b0;
  logic [A_IW-1:0] in_idx;
  logic [A_NW-1:0] neu_idx;
  logic            bias_sel, ack_mac, ack_layer, busy;

  logic            b_start = 1'b0, b_ack = 1'b0, b_rdy = 1'b0;
  logic [0:0]      b_in, b_neu;
  logic            b_bias, b_mac, b_layer, b_busy;

  always #5 clk = ~clk;

  layer_mac_sequencer #(.N_IN(A_IN), .N_OUT(A_OUT), .IW(A_IW), .NW(A_NW)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ack        (ack),
    .mac_rdy    (mac_rdy),
    .in_idx     (in_idx),
    .neu_idx    (neu_idx),
    .bias_sel   (bias_sel),
    .ack__mac   (ack_mac),
    .ack__layer (ack_layer),
    .busy       (busy)
  );

  layer_mac_sequencer #(.N_IN(1), .N_OUT(1), .IW(1), .NW(1)) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .start      (b_start),
    .ack        (b_ack),
    .mac_rdy    (b_rdy),
    .in_idx     (b_in),
    .neu_idx    (b_neu),
    .bias_sel   (b_bias),
    .ack__mac   (b_mac),
    .ack__layer (b_layer),
    .busy       (b_busy)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit layer;
    int neu;
    int in;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   mac_pushed   = 0;
  int   layer_pushed = 0;
  int   mac_rises    = 0;
  int   layer_seen   = 0;
  logic mac_prev     = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic exp_t mk(input bit l, input int n, input int i);
    exp_t e;
    e.layer = l;
    e.neu   = n;
    e.in    = i;
    return e;
  endfunction

  task automatic push_mac(input int n, input int i);
    exp_q.push_back(mk(1'b0, n, i));
    mac_pushed++;
  endtask

  task automatic push_layer();
    exp_q.push_back(mk(1'b1, 0, 0));
    layer_pushed++;
  endtask

  // monitor: samples on the rising edge, away from the DUT's falling-edge updates
  always @(posedge clk) begin
    if (rst) begin
      if (ack_mac && !mac_prev) begin
        mac_rises++;
        if (exp_q.size() == 0) chk("unexpected_ack_mac", exp_q.size(), 1);
        else begin
          mon_e = exp_q.pop_front();
          chk("mac_kind", mon_e.layer, 0);
          chk("mac_neu_idx", neu_idx, mon_e.neu);
          chk("mac_in_idx", in_idx, mon_e.in);
        end
      end
      if (ack_layer) begin
        layer_seen++;
        if (exp_q.size() == 0) chk("unexpected_ack_layer", exp_q.size(), 1);
        else begin
          mon_e = exp_q.pop_front();
          chk("layer_kind", mon_e.layer, 1);
          chk("layer_neu_idx", neu_idx, mon_e.neu);
          chk("layer_in_idx", in_idx, mon_e.in);
        end
      end
    end
    mac_prev = ack_mac;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_idx"}, in_idx, 0);
    chk({tag, "_neu_idx"}, neu_idx, 0);
    chk({tag, "_bias_sel"}, bias_sel, 0);
    chk({tag, "_ack_mac"}, ack_mac, 0);
    chk({tag, "_ack_layer"}, ack_layer, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic run_neuron(input int n, input bit gap_en, input int hold, input bit rdy_acc);
    for (int i = 0; i < NACK; i++) begin
      int g;
      g = gap_en ? (n + i) % 3 : 0;
      mac_rdy = rdy_acc;
      for (int k = 0; k < g; k++) begin
        ack = 1'b0;
        start = 1'b1;
        cyc();
        chk("gap_in_idx", in_idx, i);
      end
      start = 1'b0;
      chk("in_idx", in_idx, i);
      chk("neu_idx", neu_idx, n);
      chk("bias_sel", bias_sel, (i == A_IN));
      if (i == NACK - 1) push_mac(n, i);
      ack = 1'b1;
      cyc();
    end
    ack = 1'b0;
    chk("fire_ack_mac", ack_mac, 1);
    chk("fire_bias_sel", bias_sel, 0);
    chk("fire_busy", busy, 1);
    for (int k = 0; k < hold; k++) begin
      mac_rdy = 1'b0;
      ack = 1'b1;
      start = 1'b1;
      cyc();
      chk("held_ack_mac", ack_mac, 1);
      chk("held_in_idx", in_idx, NACK - 1);
      chk("held_neu_idx", neu_idx, n);
    end
    ack = 1'b0;
    start = 1'b0;
    if (n == A_OUT - 1) push_layer();
    mac_rdy = 1'b1;
    cyc();
    mac_rdy = 1'b0;
    chk("accept_ack_mac", ack_mac, 0);
    chk("accept_in_idx", in_idx, 0);
    if (n == A_OUT - 1) begin
      chk("end_ack_layer", ack_layer, 1);
      chk("end_busy", busy, 0);
      chk("end_neu_idx", neu_idx, 0);
    end else begin
      chk("next_ack_layer", ack_layer, 0);
      chk("next_busy", busy, 1);
      chk("next_neu_idx", neu_idx, n + 1);
    end
  endtask

  task automatic run_layer(input bit gap_en, input int hold, input bit rdy_acc);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_in_idx", in_idx, 0);
    chk("start_neu_idx", neu_idx, 0);
    chk("start_ack_layer", ack_layer, 0);
    for (int n = 0; n < A_OUT; n++) run_neuron(n, gap_en, hold, rdy_acc);
  endtask

  task automatic run_layer_b();
    for (int i = 0; i < NACK_B; i++) begin
      chk("b_in_idx", b_in, i);
      chk("b_bias_sel", b_bias, (i == 1));
      b_ack = 1'b1;
      cyc();
    end
    b_ack = 1'b0;
    chk("b_ack_mac", b_mac, 1);
    chk("b_fire_in_idx", b_in, NACK_B - 1);
    cyc();
    chk("b_ack_layer", b_layer, 1);
    chk("b_end_busy", b_busy, 0);
    chk("b_end_ack_mac", b_mac, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc();
    chk_idle("reset");
    chk("b_reset_busy", b_busy, 0);
    chk("b_reset_ack_mac", b_mac, 0);
    rst = 1'b1;
    cyc();

    // back-to-back layers: first with mac_rdy already high, second with gaps and back-pressure
    run_layer(1'b0, 0, 1'b1);
    run_layer(1'b1, 5, 1'b0);
    cyc();
    chk("after_ack_layer", ack_layer, 0);
    chk("after_busy", busy, 0);

    // asynchronous reset mid-ACC at in_idx=1, neu_idx=2
    start = 1'b1;
    cyc();
    start = 1'b0;
    run_neuron(0, 1'b0, 0, 1'b0);
    run_neuron(1, 1'b0, 0, 1'b0);
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    chk("pre_rst_in_idx", in_idx, 1);
    chk("pre_rst_neu_idx", neu_idx, 2);
    #2 rst = 1'b0;
    #1 chk_idle("async_rst");
    cyc();
    rst = 1'b1;
    ack = 1'b1;
    mac_rdy = 1'b1;
    for (int k = 0; k < NACK + 2; k++) begin
      cyc();
      chk("post_rst_busy", busy, 0);
      chk("post_rst_ack_mac", ack_mac, 0);
    end
    ack = 1'b0;
    mac_rdy = 1'b0;
    run_layer(1'b0, 1, 1'b0);
    cyc();
    chk("final_busy", busy, 0);

    // single-input single-neuron instance: busy starts ignored, restart right after ack__layer
    b_rdy = 1'b1;
    b_start = 1'b1;
    cyc();
    chk("b_start_busy", b_busy, 1);
    run_layer_b();
    cyc();
    chk("b_restart_busy", b_busy, 1);
    chk("b_restart_ack_layer", b_layer, 0);
    chk("b_restart_in_idx", b_in, 0);
    b_start = 1'b0;
    run_layer_b();
    cyc();
    chk("b_final_busy", b_busy, 0);
    chk("b_final_ack_layer", b_layer, 0);

    repeat (3) cyc();
    chk("queue_empty", exp_q.size(), 0);
    chk("mac_rise_count", mac_rises, mac_pushed);
    chk("layer_count", layer_seen, layer_pushed);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
